// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: START/STOP sequencer driving a 74x161-style 4-bit counter as a repeating interval timer.
// Optional feature macro: TIMER_PAUSE_EN (adds the PAUSE input that freezes counting in RUN).
`default_nettype none

module timer_seq_ctrl (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic       STOP,
  input  logic [3:0] PRESET,
  input  logic [3:0] REPS,
`ifdef TIMER_PAUSE_EN
  input  logic       PAUSE,
`endif
  input  logic       RCO,
  output logic [3:0] D,
  output logic       LOAD_n,
  output logic       ENP,
  output logic       ENT,
  output logic       CLR_n,
  output logic       BUSY,
  output logic       TICK,
  output logic       DONE,
  output logic [3:0] REPS_LEFT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] reps_left_nxt;
  logic       done_nxt;
  logic       capture;
  logic       pause;

`ifdef TIMER_PAUSE_EN
  assign pause = PAUSE;
`else
  assign pause = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    reps_left_nxt = REPS_LEFT;
    done_nxt      = 1'b0;
    capture       = 1'b0;
    LOAD_n        = 1'b1;
    ENP           = 1'b0;
    ENT           = 1'b0;
    CLR_n         = ~CLR;
    TICK          = 1'b0;

    case (state)
      IDLE: begin
        if (START && !STOP) begin
          state_nxt     = LOAD;
          capture       = 1'b1;
          reps_left_nxt = REPS;
        end
      end
      LOAD: begin
        if (STOP) begin
          CLR_n         = 1'b0;
          state_nxt     = IDLE;
          reps_left_nxt = 4'd0;
        end else begin
          LOAD_n    = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ENP = ~pause;
        ENT = ~pause;
        if (STOP) begin
          CLR_n         = 1'b0;
          state_nxt     = IDLE;
          reps_left_nxt = 4'd0;
        end else if (RCO && !pause) begin
          // Reload instead of wrapping; REPS_LEFT==0 here means continuous mode.
          TICK   = 1'b1;
          LOAD_n = 1'b0;
          if (REPS_LEFT == 4'd1) begin
            state_nxt     = IDLE;
            reps_left_nxt = 4'd0;
            done_nxt      = 1'b1;
          end else if (REPS_LEFT != 4'd0) begin
            reps_left_nxt = REPS_LEFT - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (CLR) begin
      LOAD_n = 1'b1;
      ENP    = 1'b0;
      ENT    = 1'b0;
      TICK   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      D         <= 4'd0;
      REPS_LEFT <= 4'd0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_nxt;
      REPS_LEFT <= reps_left_nxt;
      DONE      <= done_nxt;
      if (capture) D <= PRESET;
    end
  end

  assign BUSY = (state == LOAD) || (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_timer_seq_ctrl.sv
// tb_timer_seq_ctrl: directed bench with a behavioural 74x161 counter closing the loop around the sequencer.
`default_nettype none

module tb_timer_seq_ctrl;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       START, STOP;
  logic [3:0] PRESET, REPS;
`ifdef TIMER_PAUSE_EN
  logic       PAUSE;
`endif
  logic       RCO;
  logic [3:0] D;
  logic       LOAD_n, ENP, ENT, CLR_n, BUSY, TICK, DONE;
  logic [3:0] REPS_LEFT;
  logic [3:0] q = 4'h5;

  int checks = 0;
  int errors = 0;

  timer_seq_ctrl dut (
    .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP),
    .PRESET(PRESET), .REPS(REPS),
`ifdef TIMER_PAUSE_EN
    .PAUSE(PAUSE),
`endif
    .RCO(RCO), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT), .CLR_n(CLR_n),
    .BUSY(BUSY), .TICK(TICK), .DONE(DONE), .REPS_LEFT(REPS_LEFT)
  );

  always #5 CLK = ~CLK;

  // Counter model: clear beats load beats count.
  always @(posedge CLK) begin
    if (!CLR_n)          q <= 4'h0;
    else if (!LOAD_n)    q <= D;
    else if (ENP && ENT) q <= q + 4'h1;
  end
  assign RCO = ENT && (q == 4'hF);

  typedef struct packed {
    logic       start, stop;
    logic [3:0] preset, reps;
    logic       tick, load_n, clr_n, en, busy, done;
    logic [3:0] rl, q;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic [3:0] pr, input logic [3:0] rp, input logic pa);
    @(posedge CLK);
    #1;
    START = st; STOP = sp; PRESET = pr; REPS = rp;
`ifdef TIMER_PAUSE_EN
    PAUSE = pa;
`else
    if (pa) $display("note: pause requested without TIMER_PAUSE_EN");
`endif
    @(negedge CLK);
  endtask

  initial begin
    CLR = 1'b1; START = 1'b0; STOP = 1'b0; PRESET = 4'd0; REPS = 4'd0;
`ifdef TIMER_PAUSE_EN
    PAUSE = 1'b0;
`endif
    // PRESET=12, REPS=3: ticks at 5, 9, 13; DONE at 14.
    tbl[0]  = '{1'b1,1'b0,4'd12,4'd3, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'd0, 4'd0};
    tbl[1]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'd3, 4'd0};
    tbl[2]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd3, 4'd12};
    tbl[3]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd3, 4'd13};
    tbl[4]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd3, 4'd14};
    tbl[5]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 4'd3, 4'd15};
    tbl[6]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd2, 4'd12};
    tbl[7]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd2, 4'd13};
    tbl[8]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd2, 4'd14};
    tbl[9]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 4'd2, 4'd15};
    tbl[10] = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd1, 4'd12};
    tbl[11] = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd1, 4'd13};
    tbl[12] = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 4'd1, 4'd14};
    tbl[13] = '{1'b0,1'b0,4'd0, 4'd0, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 4'd1, 4'd15};
    tbl[14] = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 4'd0, 4'd12};
    tbl[15] = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'd0, 4'd12};

    // Reset held for two cycles.
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_clr_n", c, CLR_n, 0);
      chk("rst_load_n", c, LOAD_n, 1);
      chk("rst_en", c, {ENP, ENT}, 0);
      chk("rst_tick", c, TICK, 0);
      chk("rst_busy", c, BUSY, 0);
      chk("rst_done", c, DONE, 0);
      chk("rst_reps_left", c, REPS_LEFT, 0);
      chk("rst_d", c, D, 0);
    end
    @(posedge CLK);
    #1 CLR = 1'b0;
    @(negedge CLK);
    chk("rst_q", 0, q, 0);
    chk("rst_clr_n_release", 0, CLR_n, 1);

    // Table: three-interval run.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].start, tbl[i].stop, tbl[i].preset, tbl[i].reps, 1'b0);
      chk("tbl_tick", i, TICK, tbl[i].tick);
      chk("tbl_load_n", i, LOAD_n, tbl[i].load_n);
      chk("tbl_clr_n", i, CLR_n, tbl[i].clr_n);
      chk("tbl_enp", i, ENP, tbl[i].en);
      chk("tbl_ent", i, ENT, tbl[i].en);
      chk("tbl_busy", i, BUSY, tbl[i].busy);
      chk("tbl_done", i, DONE, tbl[i].done);
      chk("tbl_reps_left", i, REPS_LEFT, tbl[i].rl);
      chk("tbl_q", i, q, tbl[i].q);
      if (i >= 1) chk("tbl_d", i, D, 12);
    end

    // Continuous mode, PRESET=15, stopped at cycle 6.
    step(1'b1, 1'b0, 4'd15, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("cont_load_n", 1, LOAD_n, 0);
    for (int c = 2; c < 6; c++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      chk("cont_tick", c, TICK, 1);
      chk("cont_reps_left", c, REPS_LEFT, 0);
      chk("cont_busy", c, BUSY, 1);
      chk("cont_q", c, q, 15);
    end
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    chk("cont_stop_tick", 6, TICK, 0);
    chk("cont_stop_clr_n", 6, CLR_n, 0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("cont_idle_busy", 7, BUSY, 0);
    chk("cont_idle_q", 7, q, 0);
    chk("cont_idle_done", 7, DONE, 0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("cont_idle_done2", 8, DONE, 0);

    // STOP coincident with first RCO; START while busy ignored.
    step(1'b1, 1'b0, 4'd14, 4'd2, 1'b0);
    step(1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
    chk("stop_load_rl", 1, REPS_LEFT, 2);
    chk("stop_load_n", 1, LOAD_n, 0);
    step(1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
    chk("stop_run_q", 2, q, 14);
    chk("stop_run_rl", 2, REPS_LEFT, 2);
    chk("stop_run_d", 2, D, 14);
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    chk("stop_rco_q", 3, q, 15);
    chk("stop_rco_tick", 3, TICK, 0);
    chk("stop_rco_clr_n", 3, CLR_n, 0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("stop_after_q", 4, q, 0);
    chk("stop_after_rl", 4, REPS_LEFT, 0);
    chk("stop_after_busy", 4, BUSY, 0);
    chk("stop_after_done", 4, DONE, 0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("stop_after_done2", 5, DONE, 0);

    // START and STOP together in IDLE.
    step(1'b1, 1'b1, 4'd9, 4'd1, 1'b0);
    chk("ss_load_n0", 0, LOAD_n, 1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("ss_busy", 1, BUSY, 0);
    chk("ss_load_n1", 1, LOAD_n, 1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("ss_busy2", 2, BUSY, 0);
    chk("ss_q", 2, q, 0);

`ifdef TIMER_PAUSE_EN
    // PRESET=12, REPS=1, paused in cycles 3-4.
    step(1'b1, 1'b0, 4'd12, 4'd1, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("pz_q2", 2, q, 12);
    for (int c = 3; c < 5; c++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
      chk("pz_q_hold", c, q, 13);
      chk("pz_en", c, {ENP, ENT}, 0);
      chk("pz_tick", c, TICK, 0);
    end
    for (int c = 5; c < 9; c++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      chk("pz_tick_seq", c, TICK, (c == 7) ? 1 : 0);
      chk("pz_done_seq", c, DONE, (c == 8) ? 1 : 0);
    end
    chk("pz_busy_end", 8, BUSY, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
